// File: rtl/phase3_motion_sweeper.sv
// -----------------------------------------------------------------------------
// phase3_motion_sweeper
//
// Phase-3 responder for the MD step controller. On each grant it sweeps every
// particle record of the read bank, advances each position axis by
// (vel >>> DT_SHIFT) with periodic wrap, and writes the record to the
// opposite bank. When the last write has been issued it raises phase3_done
// and bumps the step counter.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   phase3_ready               grant from the control unit
//   double_buffer              read bank select (write bank is its inverse)
//   n_particles                record count, sampled at sweep start
//   phase3_done                sweep complete, held until the grant drops
//   step                       completed-step counter (wraps at 2^32)
//   rd_en/rd_bank/rd_addr      read request to the particle memory
//   rd_data                    {vz,vy,vx,pz,py,px}, valid READ_LAT cycles later
//   wr_en/wr_bank/wr_addr      write strobe to the particle memory
//   wr_data                    updated record, same packing
//   wrap_count                 records with any wrapped axis (optional)
//
// Optional feature macro: PHASE3_WRAP_STAT_EN adds the wrap_count output.
// -----------------------------------------------------------------------------
module phase3_motion_sweeper #(
   parameter int ADDR_W   = 10,
   parameter int POS_W    = 16,
   parameter int VEL_W    = 16,
   parameter int DT_SHIFT = 4,
   parameter int READ_LAT = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           phase3_ready,
   input  logic                           double_buffer,
   input  logic [ADDR_W:0]                n_particles,
   output logic                           phase3_done,
   output logic [31:0]                    step,
   output logic                           rd_en,
   output logic                           rd_bank,
   output logic [ADDR_W-1:0]              rd_addr,
   input  logic [3*(POS_W+VEL_W)-1:0]     rd_data,
   output logic                           wr_en,
   output logic                           wr_bank,
   output logic [ADDR_W-1:0]              wr_addr,
   output logic [3*(POS_W+VEL_W)-1:0]     wr_data
`ifdef PHASE3_WRAP_STAT_EN
   ,
   output logic [31:0]                    wrap_count
`endif
);

   localparam int REC_W = 3 * (POS_W + VEL_W);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t              state, state_nx;
   logic                bank;
   logic [ADDR_W:0]     cnt;
   logic [ADDR_W-1:0]   addr;
   logic                last_addr;

   logic [READ_LAT-1:0] vld_pipe;
   logic [ADDR_W-1:0]   addr_pipe [READ_LAT];
   logic                rd_valid;
   logic [REC_W-1:0]    upd_data;
`ifdef PHASE3_WRAP_STAT_EN
   logic                any_wrap;
`endif

   // Position update for one axis; the truncating add gives periodic wrap.
   function automatic logic [POS_W-1:0] axis_pos(input logic [POS_W-1:0] p,
                                                  input logic [VEL_W-1:0] v);
      logic signed [VEL_W-1:0] dv;
      dv = $signed(v) >>> DT_SHIFT;
      return p + POS_W'(dv);
   endfunction

   assign last_addr = ({1'b0, addr} == cnt - (ADDR_W+1)'(1));
   assign rd_valid  = vld_pipe[READ_LAT-1];

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nx    = state;
      rd_en       = 1'b0;
      rd_bank     = bank;
      rd_addr     = addr;
      phase3_done = 1'b0;
      case (state)
         IDLE: begin
            // An empty sweep goes straight to DONE with no memory traffic.
            if (phase3_ready) state_nx = (n_particles == '0) ? DONE : SWEEP;
         end
         SWEEP: begin
            rd_en = 1'b1;
            if (last_addr) state_nx = DRAIN;
         end
         DRAIN: begin
            // Empty read pipe means the final write is on the bus this cycle.
            if (vld_pipe == '0) state_nx = DONE;
         end
         DONE: begin
            phase3_done = 1'b1;
            if (!phase3_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         bank  <= 1'b0;
         cnt   <= '0;
         addr  <= '0;
         step  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && phase3_ready) begin
            bank <= double_buffer;
            cnt  <= n_particles;
            addr <= '0;
         end else if (state == SWEEP) begin
            addr <= addr + ADDR_W'(1);
         end
         if (state != DONE && state_nx == DONE) step <= step + 32'd1;
      end
   end

   // Valid bits track reads in flight; they are cleared by reset so an
   // aborted sweep issues no further writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_en;
         for (int i = 1; i < READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // NOTE: the address shadow is not reset; it is only ever consumed
   // alongside a valid bit, which is.
   always_ff @(posedge clk) begin
      addr_pipe[0] <= rd_addr;
      for (int i = 1; i < READ_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
   end

   always_comb begin
      upd_data = rd_data;
`ifdef PHASE3_WRAP_STAT_EN
      any_wrap = 1'b0;
`endif
      for (int i = 0; i < 3; i++) begin
         upd_data[i*POS_W +: POS_W] = axis_pos(rd_data[i*POS_W +: POS_W],
                                               rd_data[3*POS_W + i*VEL_W +: VEL_W]);
`ifdef PHASE3_WRAP_STAT_EN
         // Negative step: borrow iff the result grew. Non-negative: carry iff it shrank.
         if (rd_data[3*POS_W + i*VEL_W + VEL_W - 1]) begin
            if (upd_data[i*POS_W +: POS_W] > rd_data[i*POS_W +: POS_W]) any_wrap = 1'b1;
         end else if (upd_data[i*POS_W +: POS_W] < rd_data[i*POS_W +: POS_W]) begin
            any_wrap = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en      <= 1'b0;
         wr_bank    <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
`ifdef PHASE3_WRAP_STAT_EN
         wrap_count <= '0;
`endif
      end else begin
         wr_en <= rd_valid;
         if (rd_valid) begin
            wr_bank <= ~bank;
            wr_addr <= addr_pipe[READ_LAT-1];
            wr_data <= upd_data;
`ifdef PHASE3_WRAP_STAT_EN
            if (any_wrap) wrap_count <= wrap_count + 32'd1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_phase3_motion_sweeper.sv
module tb_phase3_motion_sweeper;

   typedef struct packed {
      logic        bank;
      logic [9:0]  addr;
      logic [95:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   // Instance with READ_LAT=1
   logic        ready, db;
   logic [10:0] n;
   logic        done;
   logic [31:0] step;
   logic        rd_en, rd_bank, wr_en, wr_bank;
   logic [9:0]  rd_addr, wr_addr;
   logic [95:0] rd_data, wr_data, rd_q;
   // Instance with READ_LAT=3
   logic        ready3, db3;
   logic [10:0] n3;
   logic        done3;
   logic [31:0] step3;
   logic        rd_en3, rd_bank3, wr_en3, wr_bank3;
   logic [9:0]  rd_addr3, wr_addr3;
   logic [95:0] rd_data3, wr_data3, p0, p1, p2;
`ifdef PHASE3_WRAP_STAT_EN
   logic [31:0] wrap_count, wrap_count3;
`endif

   logic [95:0] mem [2][1024];
   wr_t         exp_q[$];
   int          rq[$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   phase3_motion_sweeper #(.READ_LAT(1)) dut (
      .clk(clk), .reset(reset), .phase3_ready(ready), .double_buffer(db),
      .n_particles(n), .phase3_done(done), .step(step),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef PHASE3_WRAP_STAT_EN
      , .wrap_count(wrap_count)
`endif
   );

   phase3_motion_sweeper #(.READ_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .phase3_ready(ready3), .double_buffer(db3),
      .n_particles(n3), .phase3_done(done3), .step(step3),
      .rd_en(rd_en3), .rd_bank(rd_bank3), .rd_addr(rd_addr3), .rd_data(rd_data3),
      .wr_en(wr_en3), .wr_bank(wr_bank3), .wr_addr(wr_addr3), .wr_data(wr_data3)
`ifdef PHASE3_WRAP_STAT_EN
      , .wrap_count(wrap_count3)
`endif
   );

   function automatic logic [95:0] gen3(input int a);
      logic [15:0] px, py, pz, vx, vy, vz;
      px = 16'(a * 37);
      py = 16'(65535 - a * 5);
      pz = 16'(a * 997);
      vx = 16'(a * 64 - 30000);
      vy = 16'(-a * 3);
      vz = 16'(a * 11);
      return {vz, vy, vx, pz, py, px};
   endfunction

   // Reference update: integer floor-shift of the signed velocity, mod 2^16.
   function automatic logic [95:0] model_upd(input logic [95:0] r);
      logic [95:0] o;
      o = r;
      for (int i = 0; i < 3; i++) begin
         int p, v, s;
         p = int'(r[i*16 +: 16]);
         v = int'($signed(r[48 + i*16 +: 16]));
         s = p + (v >>> 4);
         o[i*16 +: 16] = s[15:0];
      end
      return o;
   endfunction

   // Memory models: 1-cycle read for dut, 3-cycle generated data for dut3.
   always @(posedge clk) rd_q <= mem[rd_bank][rd_addr];
   assign rd_data = rd_q;

   always @(posedge clk) begin
      p0 <= gen3(int'(rd_addr3));
      p1 <= p0;
      p2 <= p1;
   end
   assign rd_data3 = p2;

   // Runs one sweep on dut after the grant has been driven; returns the cycle
   // (1 = first negedge after the grant) at which phase3_done was seen.
   task automatic run_sweep(input string name, input logic bank, input int cnt,
                            output int done_cyc);
      int  rd_cnt;
      int  t;
      wr_t e;
      done_cyc = -1;
      rd_cnt   = 0;
      rq.delete();
      for (int c = 1; c <= cnt + 20 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (rd_en) begin
            checks++;
            if (rd_addr !== 10'(rd_cnt) || rd_bank !== bank) begin
               failures++;
               $display("FAIL %s rd: got addr=%0d bank=%0b, exp addr=%0d bank=%0b",
                        name, rd_addr, rd_bank, rd_cnt, bank);
            end
            rq.push_back(c);
            rd_cnt++;
         end
         if (wr_en) begin
            checks++;
            if (exp_q.size() == 0 || rq.size() == 0) begin
               failures++;
               $display("FAIL %s unexpected write addr=%0d bank=%0b", name, wr_addr, wr_bank);
            end else begin
               e = exp_q.pop_front();
               t = rq.pop_front();
               if ({wr_bank, wr_addr, wr_data} !== e || c - t != 2) begin
                  failures++;
                  $display("FAIL %s wr: got bank=%0b addr=%0d data=%h lat=%0d, exp bank=%0b addr=%0d data=%h lat=2",
                           name, wr_bank, wr_addr, wr_data, c - t, e.bank, e.addr, e.data);
               end
            end
         end
         if (done) done_cyc = c;
      end
      checks++;
      if (done_cyc < 0) begin
         failures++;
         $display("FAIL %s timeout: phase3_done got=0 exp=1", name);
      end
      checks++;
      if (rd_cnt != cnt) begin
         failures++;
         $display("FAIL %s read count got=%0d exp=%0d", name, rd_cnt, cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s missing writes got=%0d exp=0 left", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ready = 1'b0; db = 1'b0; n = '0;
      ready3 = 1'b0; db3 = 1'b0; n3 = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b0 || step !== 32'd0 || rd_en !== 1'b0 || wr_en !== 1'b0 ||
          rd_addr !== 10'd0 || rd_bank !== 1'b0 || wr_addr !== 10'd0 ||
          wr_bank !== 1'b0 || wr_data !== 96'd0) begin
         failures++;
         $display("FAIL reset_state: done=%0b step=%0d rd_en=%0b wr_en=%0b rd_addr=%0d wr_addr=%0d wr_data=%h exp all 0",
                  done, step, rd_en, wr_en, rd_addr, wr_addr, wr_data);
      end
`ifdef PHASE3_WRAP_STAT_EN
      checks++;
      if (wrap_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_wrap_count got=%0d exp=0", wrap_count);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int dc;
      for (int k = 0; k < 4; k++) begin
         mem[0][k] = {{3{16'h0040}}, {3{16'h0100 + 16'(k)}}};
         exp_q.push_back({1'b1, 10'(k), {3{16'h0040}}, {3{16'h0104 + 16'(k)}}});
      end
      @(negedge clk);
      db = 1'b0; n = 11'd4; ready = 1'b1;
      run_sweep("basic", 1'b0, 4, dc);
      checks++;
      if (dc != 7 || step !== 32'd1) begin
         failures++;
         $display("FAIL basic_done: cycle=%0d step=%0d, exp cycle=7 step=1", dc, step);
      end
   endtask

   task automatic test_handshake();
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done !== 1'b1 || step !== 32'd1 || rd_en !== 1'b0 || wr_en !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_done: %0d bad cycles got done=%0b step=%0d, exp done=1 step=1", bad, done, step);
      end
      ready = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL drop_done got=%0b exp=0", done);
      end
   endtask

   task automatic test_wrap_bank1();
      int dc;
      mem[1][0] = {16'h0000, 16'h0000, 16'h0040, 16'h2000, 16'h1000, 16'hFFFE};
      mem[1][1] = {16'h0000, 16'h0000, 16'hFFC0, 16'h2000, 16'h1000, 16'h0002};
      exp_q.push_back({1'b0, 10'd0, 16'h0000, 16'h0000, 16'h0040, 16'h2000, 16'h1000, 16'h0002});
      exp_q.push_back({1'b0, 10'd1, 16'h0000, 16'h0000, 16'hFFC0, 16'h2000, 16'h1000, 16'hFFFE});
      db = 1'b1; n = 11'd2; ready = 1'b1;
      run_sweep("wrap_bank1", 1'b1, 2, dc);
      checks++;
      if (dc != 5 || step !== 32'd2) begin
         failures++;
         $display("FAIL wrap_done: cycle=%0d step=%0d, exp cycle=5 step=2", dc, step);
      end
`ifdef PHASE3_WRAP_STAT_EN
      checks++;
      if (wrap_count !== 32'd2) begin
         failures++;
         $display("FAIL wrap_count got=%0d exp=2", wrap_count);
      end
`endif
      ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero();
      int dc;
      db = 1'b0; n = 11'd0; ready = 1'b1;
      run_sweep("zero", 1'b0, 0, dc);
      checks++;
      if (dc != 1 || step !== 32'd3) begin
         failures++;
         $display("FAIL zero_done: cycle=%0d step=%0d, exp cycle=1 step=3", dc, step);
      end
      ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int  dc;
      logic hit;
      hit = 1'b0;
      for (int k = 4; k < 8; k++) mem[0][k] = gen3(k + 100);
      db = 1'b0; n = 11'd8; ready = 1'b1;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 10'd2) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL reset_mid timeout: rd_addr 2 got=no exp=yes");
      end
      reset = 1'b1;
      ready = 1'b0;
      #1;
      checks++;
      if (wr_en !== 1'b0 || step !== 32'd0 || done !== 1'b0 || rd_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_abort: wr_en=%0b step=%0d done=%0b rd_en=%0b exp 0 0 0 0",
                  wr_en, step, done, rd_en);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, 10'(k), model_upd(mem[0][k])});
      ready = 1'b1;
      run_sweep("restart", 1'b0, 8, dc);
      checks++;
      if (dc != 11 || step !== 32'd1) begin
         failures++;
         $display("FAIL restart_done: cycle=%0d step=%0d, exp cycle=11 step=1", dc, step);
      end
      ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_long_lat3();
      int dc, rd_cnt, wr_cnt, t;
      dc = -1; rd_cnt = 0; wr_cnt = 0;
      rq.delete();
      db3 = 1'b0; n3 = 11'd1024; ready3 = 1'b1;
      for (int c = 1; c <= 1100 && dc < 0; c++) begin
         @(negedge clk);
         if (rd_en3) begin
            checks++;
            if (rd_addr3 !== 10'(rd_cnt) || rd_bank3 !== 1'b0) begin
               failures++;
               $display("FAIL lat3 rd: got addr=%0d bank=%0b, exp addr=%0d bank=0", rd_addr3, rd_bank3, rd_cnt);
            end
            rq.push_back(c);
            rd_cnt++;
         end
         if (wr_en3) begin
            t = (rq.size() != 0) ? rq.pop_front() : -100;
            checks++;
            if (c - t != 4 || wr_addr3 !== 10'(wr_cnt) || wr_bank3 !== 1'b1 ||
                wr_data3 !== model_upd(gen3(wr_cnt))) begin
               failures++;
               $display("FAIL lat3 wr: got lat=%0d addr=%0d bank=%0b data=%h, exp lat=4 addr=%0d bank=1 data=%h",
                        c - t, wr_addr3, wr_bank3, wr_data3, wr_cnt, model_upd(gen3(wr_cnt)));
            end
            wr_cnt++;
         end
         if (done3) dc = c;
      end
      checks++;
      if (dc != 1029 || wr_cnt != 1024 || rd_cnt != 1024 || step3 !== 32'd1) begin
         failures++;
         $display("FAIL lat3_done: cycle=%0d writes=%0d reads=%0d step=%0d, exp 1029 1024 1024 1",
                  dc, wr_cnt, rd_cnt, step3);
      end
      ready3 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_handshake();
      test_wrap_bank1();
      test_zero();
      test_reset_mid();
      test_long_lat3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
